// File: rtl/ram_tdp_arb.sv
// Round-robin arbiter sharing one true-dual-port RAM among NREQ requesters; read data returns after one cycle.
// Define RAM_TDP_ARB_STATS_EN to enable the saturating deferred-write counter on stat_defer_cnt.
module ram_tdp_arb #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*AWIDTH-1:0]   req_addr,
    input  logic [NREQ*DWIDTH-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [NREQ*DWIDTH-1:0]   rsp_rdata,
    output logic                     cs_0,
    output logic                     oe_0,
    output logic                     we_0,
    output logic [AWIDTH-1:0]        addr_0,
    output logic [DWIDTH-1:0]        din_0,
    input  logic [DWIDTH-1:0]        dout_0,
    output logic                     cs_1,
    output logic                     oe_1,
    output logic                     we_1,
    output logic [AWIDTH-1:0]        addr_1,
    output logic [DWIDTH-1:0]        din_1,
    input  logic [DWIDTH-1:0]        dout_1,
    output logic [15:0]              stat_defer_cnt
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic          rd_pend0_q, rd_pend0_d, rd_pend1_q, rd_pend1_d;
    logic [IW-1:0] rd_idx0_q, rd_idx0_d, rd_idx1_q, rd_idx1_d;

    logic          g0_vld, g1_vld;
    logic [IW-1:0] g0_idx, g1_idx, scan_idx;
`ifdef RAM_TDP_ARB_STATS_EN
    logic          defer, second_seen;
`endif

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (int'(v) == NREQ - 1) ? '0 : v + 1'b1;
    endfunction

    // Scan from rr_ptr; port 1 skips writes when port 0 already holds the cycle's single write.
    always_comb begin
        // NOTE: combinational blocks use blocking assignments and default every output first, so no latch is inferred.
        g0_vld   = 1'b0;
        g0_idx   = '0;
        g1_vld   = 1'b0;
        g1_idx   = '0;
        scan_idx = '0;
`ifdef RAM_TDP_ARB_STATS_EN
        defer       = 1'b0;
        second_seen = 1'b0;
`endif
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                scan_idx = IW'((int'(rr_ptr_q) + k) % NREQ);
                if (req_valid[scan_idx]) begin
                    if (!g0_vld) begin
                        g0_vld = 1'b1;
                        g0_idx = scan_idx;
                    end else if (!g1_vld) begin
                        if (!(req_we[g0_idx] && req_we[scan_idx])) begin
                            g1_vld = 1'b1;
                            g1_idx = scan_idx;
                        end
`ifdef RAM_TDP_ARB_STATS_EN
                        else if (!second_seen) begin
                            defer = 1'b1;
                        end
                        second_seen = 1'b1;
`endif
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if ((g0_vld && g0_idx == IW'(i)) || (g1_vld && g1_idx == IW'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    always_comb begin
        cs_0   = g0_vld;
        oe_0   = g0_vld && !req_we[g0_idx];
        we_0   = g0_vld && req_we[g0_idx];
        addr_0 = g0_vld ? req_addr[g0_idx*AWIDTH +: AWIDTH] : '0;
        din_0  = (g0_vld && req_we[g0_idx]) ? req_wdata[g0_idx*DWIDTH +: DWIDTH] : '0;
        cs_1   = g1_vld;
        oe_1   = g1_vld && !req_we[g1_idx];
        we_1   = g1_vld && req_we[g1_idx];
        addr_1 = g1_vld ? req_addr[g1_idx*AWIDTH +: AWIDTH] : '0;
        din_1  = (g1_vld && req_we[g1_idx]) ? req_wdata[g1_idx*DWIDTH +: DWIDTH] : '0;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (g1_vld) begin
            rr_ptr_d = wrap_inc(g1_idx);
        end else if (g0_vld) begin
            rr_ptr_d = wrap_inc(g0_idx);
        end
        rd_pend0_d = g0_vld && !req_we[g0_idx];
        rd_pend1_d = g1_vld && !req_we[g1_idx];
        rd_idx0_d  = g0_idx;
        rd_idx1_d  = g1_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            rd_pend0_q <= 1'b0;
            rd_pend1_q <= 1'b0;
            rd_idx0_q  <= '0;
            rd_idx1_q  <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rd_pend0_q <= rd_pend0_d;
            rd_pend1_q <= rd_pend1_d;
            rd_idx0_q  <= rd_idx0_d;
            rd_idx1_q  <= rd_idx1_d;
        end
    end

    // Gating with rst drops a response whose read was granted just before reset.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rd_pend0_q && rd_idx0_q == IW'(i)) begin
                    rsp_valid[i]                    = 1'b1;
                    rsp_rdata[i*DWIDTH +: DWIDTH]   = dout_0;
                end else if (rd_pend1_q && rd_idx1_q == IW'(i)) begin
                    rsp_valid[i]                    = 1'b1;
                    rsp_rdata[i*DWIDTH +: DWIDTH]   = dout_1;
                end
            end
        end
    end

`ifdef RAM_TDP_ARB_STATS_EN
    logic [15:0] defer_cnt_q, defer_cnt_d;

    assign defer_cnt_d = (defer && defer_cnt_q != 16'hFFFF) ? defer_cnt_q + 16'd1 : defer_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            defer_cnt_q <= '0;
        end else begin
            defer_cnt_q <= defer_cnt_d;
        end
    end

    assign stat_defer_cnt = defer_cnt_q;
`else
    assign stat_defer_cnt = '0;
`endif

endmodule

// File: tb/tb_ram_tdp_arb.sv
// Directed bench for ram_tdp_arb with a behavioural dual-port RAM (registered dout, read-before-write).
module tb_ram_tdp_arb;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int AW   = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_we = '0;
    logic [NREQ*AW-1:0]  req_addr = '0;
    logic [NREQ*DW-1:0]  req_wdata = '0;
    logic [NREQ-1:0]     req_ready, rsp_valid;
    logic [NREQ*DW-1:0]  rsp_rdata;
    logic                cs_0, oe_0, we_0, cs_1, oe_1, we_1;
    logic [AW-1:0]       addr_0, addr_1;
    logic [DW-1:0]       din_0, din_1, dout_0, dout_1;
    logic [15:0]         stat_defer_cnt;

    logic [DW-1:0]       mem [16];
    int                  vectors = 0;
    int                  miscompares = 0;
    int                  grant_cnt [NREQ];
    logic [NREQ-1:0]     prev_ready;

`ifdef RAM_TDP_ARB_STATS_EN
    localparam logic [15:0] DEF1 = 16'd1;
    localparam logic [15:0] DEF2 = 16'd2;
`else
    localparam logic [15:0] DEF1 = 16'd0;
    localparam logic [15:0] DEF2 = 16'd0;
`endif

    ram_tdp_arb #(.NREQ(NREQ), .DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .cs_0(cs_0), .oe_0(oe_0), .we_0(we_0), .addr_0(addr_0), .din_0(din_0), .dout_0(dout_0),
        .cs_1(cs_1), .oe_1(oe_1), .we_1(we_1), .addr_1(addr_1), .din_1(din_1), .dout_1(dout_1),
        .stat_defer_cnt(stat_defer_cnt)
    );

    always #5 clk = ~clk;

    // RAM model: only one write commits per cycle, port 0 first.
    always @(posedge clk) begin
        if (cs_0 && oe_0) dout_0 <= mem[addr_0];
        if (cs_1 && oe_1) dout_1 <= mem[addr_1];
        if (cs_0 && we_0)      mem[addr_0] <= din_0;
        else if (cs_1 && we_1) mem[addr_1] <= din_1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_we[i]            = w;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_all();
        req_valid = '0;
        req_we    = '0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[2] = 8'h3C; mem[3] = 8'hA5; mem[5] = 8'h55; mem[6] = 8'h66; mem[7] = 8'hC7;
        dout_0 = '0;
        dout_1 = '0;

        // Reset with a pending request: nothing must be granted
        set_req(0, 1'b1, 1'b0, 4'd3, 8'h00);
        next_cycle(); next_cycle();
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_cs", {30'b0, cs_0, cs_1}, 32'h0);
        check("rst_rsp", 32'(rsp_valid), 32'h0);
        check("rst_stat", 32'(stat_defer_cnt), 32'h0);

        // Single read by req 0 @3
        next_cycle();
        rst = 1'b0;
        #1;
        check("sr_ready", 32'(req_ready), 32'h1);
        check("sr_ctl0", {29'b0, cs_0, oe_0, we_0}, 32'h6);
        check("sr_addr0", 32'(addr_0), 32'h3);
        check("sr_cs1", 32'(cs_1), 32'h0);
        next_cycle();
        clear_all();
        set_req(3, 1'b1, 1'b0, 4'd6, 8'h00);  // brings rr_ptr back to 0
        #1;
        check("sr_rspv", 32'(rsp_valid), 32'h1);
        check("sr_rdata", rsp_rdata, 32'h000000A5);
        check("p3_ready", 32'(req_ready), 32'h8);

        // Dual read: req 1 @2, req 2 @7 with rr_ptr = 0
        next_cycle();
        clear_all();
        set_req(1, 1'b1, 1'b0, 4'd2, 8'h00);
        set_req(2, 1'b1, 1'b0, 4'd7, 8'h00);
        #1;
        check("p3_rdata", rsp_rdata, 32'h66000000);
        check("dr_ready", 32'(req_ready), 32'h6);
        check("dr_addr", {24'b0, addr_0, addr_1}, 32'h27);
        check("dr_ctl1", {29'b0, cs_1, oe_1, we_1}, 32'h6);
        next_cycle();
        clear_all();
        set_req(0, 1'b1, 1'b0, 4'd5, 8'h00);
        set_req(3, 1'b1, 1'b0, 4'd6, 8'h00);
        #1;
        check("dr_rspv", 32'(rsp_valid), 32'h6);
        check("dr_rdata", rsp_rdata, 32'h00C73C00);
        // rr_ptr must now be 3: req 3 wins port 0 ahead of req 0
        check("ptr3_ready", 32'(req_ready), 32'h9);
        check("ptr3_addr", {24'b0, addr_0, addr_1}, 32'h65);
        next_cycle();
        clear_all();
        set_req(3, 1'b1, 1'b0, 4'd6, 8'h00);  // rr_ptr 1 -> 0
        #1;
        check("ptr3_rdata", rsp_rdata, 32'h66000055);

        // Write deferral: req 0 writes 11@1, req 1 writes 22@2
        next_cycle();
        clear_all();
        set_req(0, 1'b1, 1'b1, 4'd1, 8'h11);
        set_req(1, 1'b1, 1'b1, 4'd2, 8'h22);
        #1;
        check("wd_ready0", 32'(req_ready), 32'h1);
        check("wd_port0", {19'b0, cs_0, oe_0, we_0, addr_0, din_0}, {19'b0, 3'b101, 4'd1, 8'h11});
        check("wd_cs1", {30'b0, cs_1, we_1}, 32'h0);
        next_cycle();
        set_req(0, 1'b0, 1'b0, 4'd0, 8'h00);
        #1;
        check("wd_stat1", 32'(stat_defer_cnt), 32'(DEF1));
        check("wd_ready1", 32'(req_ready), 32'h2);
        check("wd_port0b", {19'b0, cs_0, oe_0, we_0, addr_0, din_0}, {19'b0, 3'b101, 4'd2, 8'h22});
        next_cycle();
        clear_all();
        set_req(2, 1'b1, 1'b0, 4'd1, 8'h00);
        set_req(3, 1'b1, 1'b0, 4'd2, 8'h00);
        #1;
        check("wd_rb_ready", 32'(req_ready), 32'hC);
        next_cycle();
        clear_all();
        // Same-address collision: req 0 writes 5A@4, req 1 reads @4
        set_req(0, 1'b1, 1'b1, 4'd4, 8'h5A);
        set_req(1, 1'b1, 1'b0, 4'd4, 8'h00);
        #1;
        check("wd_rb_rdata", rsp_rdata, 32'h22110000);
        check("col_ready", 32'(req_ready), 32'h3);
        next_cycle();
        clear_all();
        set_req(0, 1'b1, 1'b0, 4'd4, 8'h00);
        #1;
        check("col_old", rsp_rdata, 32'h00000000);
        check("col_rspv", 32'(rsp_valid), 32'h2);
        next_cycle();
        clear_all();
        // Deferred write with a later read: port 1 skips req 2's write and serves req 3
        set_req(1, 1'b1, 1'b1, 4'd8, 8'h33);
        set_req(2, 1'b1, 1'b1, 4'd9, 8'h44);
        set_req(3, 1'b1, 1'b0, 4'd3, 8'h00);
        #1;
        check("col_new", rsp_rdata, 32'h0000005A);
        check("dr2_ready", 32'(req_ready), 32'hA);
        check("dr2_we", {30'b0, we_0, we_1}, 32'h2);
        next_cycle();
        set_req(1, 1'b0, 1'b0, 4'd0, 8'h00);
        set_req(3, 1'b0, 1'b0, 4'd0, 8'h00);
        #1;
        check("dr2_rdata", rsp_rdata, 32'hA5000000);
        check("dr2_stat", 32'(stat_defer_cnt), 32'(DEF2));
        check("dr2_late", 32'(req_ready), 32'h4);
        check("dr2_addr", 32'(addr_0), 32'h9);
        next_cycle();
        clear_all();
        set_req(3, 1'b1, 1'b0, 4'd3, 8'h00);  // rr_ptr 3 -> 0
        #1;
        check("fp_ready", 32'(req_ready), 32'h8);

        // Fairness: all four read continuously
        for (int i = 0; i < NREQ; i++) grant_cnt[i] = 0;
        prev_ready = '0;
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, AW'(i), 8'h00);
            #1;
            check($sformatf("fair_ready%0d", c), 32'(req_ready), (c % 2 == 0) ? 32'h3 : 32'hC);
            if (c > 0) check($sformatf("fair_rspv%0d", c), 32'(rsp_valid), 32'(prev_ready));
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) grant_cnt[i]++;
            prev_ready = req_ready;
        end
        for (int i = 0; i < NREQ; i++) check($sformatf("fair_cnt%0d", i), 32'(grant_cnt[i]), 32'd4);

        // Reset mid-operation: read granted, then reset the following cycle
        next_cycle();
        clear_all();
        set_req(1, 1'b1, 1'b0, 4'd1, 8'h00);
        #1;
        check("rm_ready", 32'(req_ready), 32'h2);
        next_cycle();
        rst = 1'b1;
        set_req(2, 1'b1, 1'b0, 4'd2, 8'h00);
        set_req(3, 1'b1, 1'b0, 4'd3, 8'h00);
        #1;
        check("rm_rspv", 32'(rsp_valid), 32'h0);
        check("rm_rdata", rsp_rdata, 32'h0);
        check("rm_gnt", {28'b0, req_ready}, 32'h0);
        check("rm_cs", {30'b0, cs_0, cs_1}, 32'h0);
        next_cycle();
        rst = 1'b0;
        #1;
        check("rm_post_ready", 32'(req_ready), 32'h6);
        check("rm_post_rspv", 32'(rsp_valid), 32'h0);
        check("rm_stat", 32'(stat_defer_cnt), 32'h0);
        next_cycle();
        clear_all();
        #1;
        check("rm_post_rdata", rsp_rdata, 32'h00221100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
